dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port (we[1:0]: 00 none, 01 sw, 10 sh, 11 sb) between the pipeline MEM stage (CPU) and an aux DMA/loader port.
//  CPU has priority by default; a wait counter bounds DMA starvation; an optional lock keeps DMA bursts contiguous.

---
 rtl/dmem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the CPU MEM
// stage and an auxiliary DMA/loader port.
//  - The CPU normally wins. A DMA request that is denied MAX_WAIT times in a
//    row is forced through on the next cycle.
//  - A DMA grant with dma_lock=1 keeps the port for the following cycles
//    until the burst ends.
//  - Optional feature macro DMEM_ARB_STATS_EN adds grant/stall counters.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_lock,
  input  logic [1:0]    dma_we,
  input  logic [AW-1:0] dma_a,
  input  logic [DW-1:0] dma_wd,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rd,
  output logic          dma_rvalid,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
`ifdef DMEM_ARB_STATS_EN
  output logic [31:0]   cpu_gnt_cnt,
  output logic [31:0]   dma_gnt_cnt,
  output logic [31:0]   stall_cnt,
`endif
  input  logic [DW-1:0] mem_rd
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_CPU, S_DMA} state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt;
  logic          wait_full;
  logic          cpu_gnt;

  assign wait_full = (wait_cnt == WW'(MAX_WAIT));

  // Owner state register; reset always returns the port to the CPU.
  always_ff @(posedge clk) begin
    if (reset) state <= S_CPU;
    else       state <= state_next;
  end

  // Next owner: enter a burst on a locked DMA grant, leave when the DMA
  // drops its request or takes an unlocked grant.
  always_comb begin
    state_next = state;
    case (state)
      S_CPU: if (dma_gnt && dma_lock) state_next = S_DMA;
      S_DMA: if (!dma_req || (dma_gnt && !dma_lock)) state_next = S_CPU;
      default: state_next = S_CPU;
    endcase
  end

  // Grant decision and port muxing; nothing is granted while in reset so a
  // pending store is dropped.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      case (state)
        S_CPU: begin
          if (cpu_req && !(dma_req && wait_full)) cpu_gnt = 1'b1;
          else if (dma_req)                       dma_gnt = 1'b1;
        end
        S_DMA: begin
          if (dma_req)      dma_gnt = 1'b1;
          else if (cpu_req) cpu_gnt = 1'b1;
        end
        default: ;
      endcase
    end
    cpu_stall = cpu_req && dma_gnt;
    mem_we    = 2'b00;
    mem_a     = '0;
    mem_wd    = '0;
    if (cpu_gnt) begin
      mem_we = cpu_we;
      mem_a  = cpu_a;
      mem_wd = cpu_wd;
    end else if (dma_gnt) begin
      mem_we = dma_we;
      mem_a  = dma_a;
      mem_wd = dma_wd;
    end
  end

  // The CPU sees dmem read data directly; it discards it while stalled.
  assign cpu_rd = mem_rd;

  // Starvation counter: counts consecutive denied DMA cycles, saturating.
  always_ff @(posedge clk) begin
    if (reset || !dma_req || dma_gnt) wait_cnt <= '0;
    else if (!wait_full)              wait_cnt <= wait_cnt + WW'(1);
  end

  // Capture DMA load data at the end of its grant cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rd     <= '0;
      dma_rvalid <= 1'b0;
    end else if (dma_gnt && dma_we == 2'b00) begin
      dma_rd     <= mem_rd;
      dma_rvalid <= 1'b1;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Free-running usage counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt_cnt <= '0;
      dma_gnt_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (cpu_gnt)   cpu_gnt_cnt <= cpu_gnt_cnt + 32'd1;
      if (dma_gnt)   dma_gnt_cnt <= dma_gnt_cnt + 32'd1;
      if (cpu_stall) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared with a transaction-level reference model. A small
// byte-writable RAM stands in for dmem.
module tb_dmem_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        creq, dreq, dlock;
  logic [1:0]  cwe, dwe;
  logic [31:0] ca, cwd, da, dwd;
  logic [31:0] cpu_rd, dma_rd, mem_a, mem_wd, mem_rd;
  logic        cpu_stall, dma_gnt, dma_rvalid;
  logic [1:0]  mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_gnt_cnt, dma_gnt_cnt, stall_cnt;
`endif

  logic [31:0] ram [0:63];
  logic [31:0] exp_mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_burst;
  int          m_wait;
  bit          m_rvalid;
  logic [31:0] m_rd;
  int          m_cg_cnt, m_dg_cnt, m_st_cnt;
  bit          last_dg;
  logic        obs_dg, obs_rvalid;
  logic [31:0] obs_dma_rd;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(rst),
    .cpu_req(creq), .cpu_we(cwe), .cpu_a(ca), .cpu_wd(cwd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dreq), .dma_lock(dlock), .dma_we(dwe), .dma_a(da), .dma_wd(dwd),
    .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
`ifdef DMEM_ARB_STATS_EN
    .cpu_gnt_cnt(cpu_gnt_cnt), .dma_gnt_cnt(dma_gnt_cnt), .stall_cnt(stall_cnt),
`endif
    .mem_rd(mem_rd)
  );

  function automatic logic [31:0] wmerge(logic [31:0] old, logic [1:0] we,
                                         logic [31:0] a, logic [31:0] wd);
    logic [31:0] r;
    int sh;
    r  = old;
    sh = int'(a[1:0]);
    case (we)
      2'b01: r = wd;
      2'b10: if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      2'b11: r[sh*8 +: 8] = wd[7:0];
      default: ;
    endcase
    return r;
  endfunction

  // dmem stand-in: combinational read, byte-lane writes on the clock edge
  assign mem_rd = ram[mem_a[7:2]];
  always @(posedge clk)
    if (mem_we != 2'b00) ram[mem_a[7:2]] <= wmerge(ram[mem_a[7:2]], mem_we, mem_a, mem_wd);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already applied; compare at negedge, then
  // advance the model at the rising edge.
  task automatic cycle();
    bit          e_cg, e_dg;
    logic [1:0]  e_we;
    logic [31:0] e_a, e_wd;
    @(negedge clk);
    e_cg = 0;
    e_dg = 0;
    if (!rst) begin
      if (m_burst) begin
        e_dg = dreq;
        e_cg = !dreq && creq;
      end else begin
        e_cg = creq && !(dreq && m_wait == MW);
        e_dg = !e_cg && dreq;
      end
    end
    e_we = e_cg ? cwe : e_dg ? dwe : 2'b00;
    e_a  = e_cg ? ca  : e_dg ? da  : 32'd0;
    e_wd = e_cg ? cwd : e_dg ? dwd : 32'd0;
    check("cpu_stall", {31'd0, cpu_stall}, {31'd0, creq && e_dg});
    check("dma_gnt", {31'd0, dma_gnt}, {31'd0, e_dg});
    check("mem_we", {30'd0, mem_we}, {30'd0, e_we});
    check("mem_a", mem_a, e_a);
    check("mem_wd", mem_wd, e_wd);
    check("cpu_rd", cpu_rd, exp_mem[e_a[7:2]]);
    check("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rvalid});
    check("dma_rd", dma_rd, m_rd);
`ifdef DMEM_ARB_STATS_EN
    check("cpu_gnt_cnt", cpu_gnt_cnt, m_cg_cnt);
    check("dma_gnt_cnt", dma_gnt_cnt, m_dg_cnt);
    check("stall_cnt", stall_cnt, m_st_cnt);
`endif
    $display("t=%0t rst=%0b creq=%0b dreq=%0b lock=%0b -> dgnt=%0b stall=%0b mem_we=%0d mem_a=%h",
             $time, rst, creq, dreq, dlock, dma_gnt, cpu_stall, mem_we, mem_a);
    obs_dg     = dma_gnt;
    @(posedge clk);
    if (rst) begin
      m_burst = 0; m_wait = 0; m_rvalid = 0; m_rd = '0;
      m_cg_cnt = 0; m_dg_cnt = 0; m_st_cnt = 0;
    end else begin
      m_rvalid = e_dg && dwe == 2'b00;
      if (m_rvalid) m_rd = exp_mem[da[7:2]];
      if (e_we != 2'b00) exp_mem[e_a[7:2]] = wmerge(exp_mem[e_a[7:2]], e_we, e_a, e_wd);
      m_wait   = (dreq && !e_dg) ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : 0;
      m_burst  = e_dg && dlock;
      m_cg_cnt += int'(e_cg);
      m_dg_cnt += int'(e_dg);
      m_st_cnt += int'(creq && e_dg);
    end
    last_dg = e_dg;
    #1;
    obs_rvalid = dma_rvalid;
    obs_dma_rd = dma_rd;
  endtask

  task automatic set_cpu(logic r, logic [1:0] we, logic [31:0] a, logic [31:0] wd);
    creq = r; cwe = we; ca = a; cwd = wd;
  endtask

  task automatic set_dma(logic r, logic l, logic [1:0] we, logic [31:0] a, logic [31:0] wd);
    dreq = r; dlock = l; dwe = we; da = a; dwd = wd;
  endtask

  initial begin
    int burst_gnts;
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    m_burst = 0; m_wait = 0; m_rvalid = 0; m_rd = '0;
    m_cg_cnt = 0; m_dg_cnt = 0; m_st_cnt = 0; last_dg = 0;
    rst = 1;
    set_cpu(0, 2'b00, 0, 0);
    set_dma(0, 0, 2'b00, 0, 0);
    @(posedge clk); #1;
    cycle();                       // reset-state checks
    rst = 0;

    // 1: CPU-only store
    set_cpu(1, 2'b01, 32'h10, 32'hDEADBEEF);
    cycle();
    check("t1_ram4", ram[4], 32'hDEADBEEF);

    // 2: contention, DMA forced through on the 5th cycle
    set_cpu(1, 2'b00, 32'h10, 0);
    set_dma(1, 0, 2'b00, 32'h20, 0);
    repeat (4) begin
      cycle();
      check("t2_cpu_wins", {31'd0, obs_dg}, 32'd0);
    end
    cycle();
    check("t2_dma_5th", {31'd0, obs_dg}, 32'd1);

    // 3: DMA byte store, CPU idle
    set_cpu(0, 2'b00, 0, 0);
    set_dma(1, 0, 2'b11, 32'h13, 32'hAB);
    cycle();
    check("t3_dgnt", {31'd0, obs_dg}, 32'd1);
    check("t3_ram4", ram[4], 32'hABADBEEF);

    // 4: DMA load with registered return
    set_dma(0, 0, 2'b00, 0, 0);
    set_cpu(1, 2'b01, 32'h8, 32'h12345678);
    cycle();
    set_cpu(0, 2'b00, 0, 0);
    set_dma(1, 0, 2'b00, 32'h8, 0);
    cycle();
    set_dma(0, 0, 2'b00, 0, 0);
    check("t4_rvalid_n1", {31'd0, obs_rvalid}, 32'd1);
    check("t4_rd_n1", obs_dma_rd, 32'h12345678);
    cycle();
    check("t4_rvalid_n2", {31'd0, obs_rvalid}, 32'd0);

    // 5: locked burst of three grants against a busy CPU
    set_cpu(1, 2'b00, 32'h0, 0);
    set_dma(1, 1, 2'b01, 32'h30, 32'h55);
    repeat (4) cycle();
    burst_gnts = 0;
    cycle(); burst_gnts += int'(obs_dg);
    cycle(); burst_gnts += int'(obs_dg);
    dlock = 0;
    cycle(); burst_gnts += int'(obs_dg);
    check("t5_burst_len", burst_gnts, 3);
    set_dma(0, 0, 2'b00, 0, 0);
    cycle();
    check("t5_back_to_cpu", {31'd0, obs_dg}, 32'd0);

    // 6: reset in the middle of a burst drops the pending stores
    set_dma(1, 1, 2'b01, 32'h34, 32'h66);
    repeat (6) cycle();
    rst = 1;
    set_cpu(1, 2'b01, 32'h3C, 32'h77);
    set_dma(1, 1, 2'b01, 32'h3C, 32'h88);
    cycle();
    check("t6_dropped", ram[15], 32'h0);
    rst = 0;
    cycle();
    check("t6_cpu_after_rst", {31'd0, obs_dg}, 32'd0);
    check("t6_cpu_store", ram[15], 32'h77);

    // random traffic; a pending DMA request is held until granted
    set_dma(0, 0, 2'b00, 0, 0);
    last_dg = 0;
    for (int n = 0; n < 600; n++) begin
      if (!(dreq && !last_dg)) begin
        set_dma($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), $urandom);
      end
      set_cpu($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              32'($urandom_range(0, 255)), $urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
